alu_rr_arbiter: RTL and testbench

- Shares one combinational ALU (ADD/SUB/AND/OR, neg/pos/zero flags) among NUM_REQ requesters.
- Round-robin arbitration; one operation accepted per cycle; result and flags captured in a single-entry output register with valid/ready backpressure.
- Sits between several datapath clients and the shared ALU; each result is tagged with the ID of the requester that issued it.

---
 rtl/alu_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin arbiter sharing one ALU among several requesters
//
// Ports:
//   clk, rst              clock (rising edge); asynchronous active-high reset
//   req_valid[NUM_REQ]    per-requester operation pending
//   req_in0/req_in1       packed operands, slice i belongs to requester i
//   req_sel               packed 2-bit opcodes (00 ADD, 01 SUB, 10 AND, 11 OR)
//   req_ready[NUM_REQ]    one-hot-or-zero grant
//   rsp_valid/rsp_ready   single-entry result register handshake
//   rsp_id                index of the requester that produced the result
//   rsp_out               ALU result
//   rsp_neg/pos/zero      sign classification of rsp_out
module alu_rr_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_in0,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*2-1:0]     req_sel,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_out,
    output logic                     rsp_neg,
    output logic                     rsp_pos,
    output logic                     rsp_zero
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic              found;
    logic              slot_free;
    logic              accept;

    logic [WIDTH-1:0]  in0_arr [NUM_REQ];
    logic [WIDTH-1:0]  in1_arr [NUM_REQ];
    logic [1:0]        sel_arr [NUM_REQ];

    logic [WIDTH-1:0]  op_a, op_b, alu_res;
    logic [1:0]        op_sel;
    logic              alu_neg, alu_pos, alu_zero;

    // The slot is reusable in the same cycle the consumer drains it,
    // which is what gives back-to-back throughput.
    assign slot_free = (state == EMPTY) || rsp_ready;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            in0_arr[k] = req_in0[k*WIDTH +: WIDTH];
            in1_arr[k] = req_in1[k*WIDTH +: WIDTH];
            sel_arr[k] = req_sel[k*2 +: 2];
        end
    end

    // Search starts at the pointer and wraps; first valid hit wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        found     = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (slot_free && !found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
        if (found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept = found;

    assign op_a   = in0_arr[grant_id];
    assign op_b   = in1_arr[grant_id];
    assign op_sel = sel_arr[grant_id];

    always_comb begin
        alu_res = '0;
        case (op_sel)
            2'b00:   alu_res = op_a + op_b;
            2'b01:   alu_res = op_a - op_b;
            2'b10:   alu_res = op_a & op_b;
            default: alu_res = op_a | op_b;
        endcase
    end

    assign alu_zero = (alu_res == '0);
    assign alu_neg  = alu_res[WIDTH-1];
    assign alu_pos  = !alu_res[WIDTH-1] && !alu_zero;

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = FULL;
        end else if (rsp_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign rsp_valid = (state == FULL);

    // Data registers load only on accept; after a plain drain they keep
    // stale contents, which is harmless because rsp_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            rsp_id   <= '0;
            rsp_out  <= '0;
            rsp_neg  <= 1'b0;
            rsp_pos  <= 1'b0;
            rsp_zero <= 1'b0;
        end else if (accept) begin
            rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            rsp_id   <= grant_id;
            rsp_out  <= alu_res;
            rsp_neg  <= alu_neg;
            rsp_pos  <= alu_pos;
            rsp_zero <= alu_zero;
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - directed self-checking bench for alu_rr_arbiter
module tb_alu_rr_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_in0 = '0;
    logic [NUM_REQ*WIDTH-1:0] req_in1 = '0;
    logic [NUM_REQ*2-1:0]     req_sel = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_out;
    logic                     rsp_neg, rsp_pos, rsp_zero;

    int checks = 0;
    int errors = 0;

    alu_rr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_in0(req_in0), .req_in1(req_in1), .req_sel(req_sel),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_neg(rsp_neg), .rsp_pos(rsp_pos), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        req_in0[i*WIDTH +: WIDTH] = a;
        req_in1[i*WIDTH +: WIDTH] = b;
        req_sel[i*2 +: 2]         = s;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        checks++; if ({rsp_id, rsp_out, rsp_neg, rsp_pos, rsp_zero} !== '0) begin errors++; $display("FAIL reset_rsp got id=%0d out=%h flags=%b%b%b exp all 0", rsp_id, rsp_out, rsp_neg, rsp_pos, rsp_zero); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_out [4];
        logic [2:0] exp_flg [4];
        int         order   [6];
        exp_out = '{8'h07, 8'hFF, 8'h08, 8'h0F};
        exp_flg = '{3'b010, 3'b100, 3'b010, 3'b010};
        order   = '{0, 1, 2, 3, 0, 1};
        set_req(0, 8'h03, 8'h04, 2'b00);
        set_req(1, 8'h03, 8'h04, 2'b01);
        set_req(2, 8'h0C, 8'h0A, 2'b10);
        set_req(3, 8'h0C, 8'h03, 2'b11);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (req_ready !== (4'b0001 << order[k])) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << order[k]); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(order[k]) || rsp_out !== exp_out[order[k]] || {rsp_neg, rsp_pos, rsp_zero} !== exp_flg[order[k]])
                begin errors++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d out=%h f=%b%b%b exp v=1 id=%0d out=%h f=%b", k, rsp_valid, rsp_id, rsp_out, rsp_neg, rsp_pos, rsp_zero, order[k], exp_out[order[k]], exp_flg[order[k]]); end
        end
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_single_sub;
        set_req(1, 8'h05, 8'h07, 2'b01);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sub_grant got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_out !== 8'hFE) begin errors++; $display("FAIL sub_rsp got v=%b id=%0d out=%h exp v=1 id=1 out=fe", rsp_valid, rsp_id, rsp_out); end
        checks++; if ({rsp_neg, rsp_pos, rsp_zero} !== 3'b100) begin errors++; $display("FAIL sub_flags got=%b%b%b exp=100", rsp_neg, rsp_pos, rsp_zero); end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sub_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_backpressure;
        set_req(0, 8'h01, 8'h02, 2'b00);
        set_req(2, 8'h09, 8'h01, 2'b01);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_out !== 8'h03 || {rsp_neg, rsp_pos, rsp_zero} !== 3'b010)
                begin errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d out=%h f=%b%b%b exp v=1 id=0 out=03 f=010", k, rsp_valid, rsp_id, rsp_out, rsp_neg, rsp_pos, rsp_zero); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_grant got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_out !== 8'h08) begin errors++; $display("FAIL bp_new_rsp got v=%b id=%0d out=%h exp v=1 id=2 out=08", rsp_valid, rsp_id, rsp_out); end
        tick();
    endtask

    task automatic test_flags;
        logic [7:0] a   [4];
        logic [7:0] b   [4];
        logic [1:0] s   [4];
        logic [7:0] eo  [4];
        logic [2:0] ef  [4];
        a  = '{8'h80, 8'hF0, 8'h80, 8'h7F};
        b  = '{8'h80, 8'h0F, 8'h01, 8'h01};
        s  = '{2'b00, 2'b10, 2'b11, 2'b00};
        eo = '{8'h00, 8'h00, 8'h81, 8'h80};
        ef = '{3'b001, 3'b001, 3'b100, 3'b100};
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_req(0, a[k], b[k], s[k]);
            req_valid = 4'b0001;
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flag_grant[%0d] got=%b exp=0001", k, req_ready); end
            tick();
            req_valid = '0;
            checks++; if (rsp_valid !== 1'b1 || rsp_out !== eo[k] || {rsp_neg, rsp_pos, rsp_zero} !== ef[k])
                begin errors++; $display("FAIL flag_rsp[%0d] got v=%b out=%h f=%b%b%b exp v=1 out=%h f=%b", k, rsp_valid, rsp_out, rsp_neg, rsp_pos, rsp_zero, eo[k], ef[k]); end
        end
        tick();
    endtask

    task automatic test_pointer_wrap;
        logic [3:0] vld [3];
        logic [3:0] gnt [3];
        int         gid [3];
        vld = '{4'b1000, 4'b0100, 4'b0101};
        gnt = '{4'b1000, 4'b0100, 4'b0001};
        gid = '{3, 2, 0};
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'h10, 2'b00);
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid = vld[k];
            #1;
            checks++; if (req_ready !== gnt[k]) begin errors++; $display("FAIL wrap_grant[%0d] got=%b exp=%b", k, req_ready, gnt[k]); end
            tick();
            req_valid = '0;
            checks++; if (rsp_id !== ID_W'(gid[k]) || rsp_out !== 8'(8'h11 + gid[k])) begin errors++; $display("FAIL wrap_rsp[%0d] got id=%0d out=%h exp id=%0d out=%h", k, rsp_id, rsp_out, gid[k], 8'(8'h11 + gid[k])); end
        end
        tick();
    endtask

    task automatic test_reset_midstream;
        set_req(1, 8'h05, 8'h06, 2'b00);
        set_req(3, 8'h01, 8'h01, 2'b00);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_out !== 8'h0B) begin errors++; $display("FAIL mid_full got v=%b out=%h exp v=1 out=0b", rsp_valid, rsp_out); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || {rsp_id, rsp_out, rsp_neg, rsp_pos, rsp_zero} !== '0)
            begin errors++; $display("FAIL mid_async_clear got v=%b id=%0d out=%h f=%b%b%b exp all 0", rsp_valid, rsp_id, rsp_out, rsp_neg, rsp_pos, rsp_zero); end
        req_valid = 4'b1010;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready); end
        tick();
        req_valid = 4'b1000;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_out !== 8'h0B) begin errors++; $display("FAIL mid_rsp got v=%b id=%0d out=%h exp v=1 id=1 out=0b", rsp_valid, rsp_id, rsp_out); end
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        checks++; if (rsp_id !== 2'd3 || rsp_out !== 8'h02) begin errors++; $display("FAIL mid_next got id=%0d out=%h exp id=3 out=02", rsp_id, rsp_out); end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_sub();
        test_backpressure();
        test_flags();
        test_pointer_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
